// File: rtl/npu_mac_pkg.sv
// Shared definitions for the radix-4 Booth MAC lane: digit codes, encoder,
// partial-product count and sign-extension prefix constants.
package npu_mac_pkg;

  // One radix-4 Booth digit: magnitude one/two and sign
  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_code_t;

  // PP_0 prefix is {~s, s, s}: this base XORed with {s, s, s}
  localparam logic [2:0] Pfx0Base = 3'b100;
  // PP_i prefix is {1, ~s}: this base XORed with {0, s}
  localparam logic [1:0] PfxIBase = 2'b11;

  // Recode the triple {b[2i+1], b[2i], b[2i-1]} into a digit in {-2..+2}
  function automatic booth_code_t booth_encode(input logic [2:0] bits);
    booth_code_t c;
    c.neg = bits[2] & ~(bits[1] & bits[0]);
    c.one = bits[1] ^ bits[0];
    c.two = (bits[2] & ~bits[1] & ~bits[0]) | (~bits[2] & bits[1] & bits[0]);
    return c;
  endfunction

  // One extra digit covers the extension bit of b
  function automatic int unsigned npp_of(input int unsigned dwb);
    return dwb / 2 + 1;
  endfunction

endpackage

// File: rtl/npu_booth_pp_gen.sv
// Combinational radix-4 Booth partial-product generator with compressed
// sign-extension prefixes. Row i carries weight 2^(2i); neg[i] is the +1
// completion of the inverted row, also at weight 2^(2i).
module npu_booth_pp_gen
  import npu_mac_pkg::*;
#(
  parameter int unsigned DWA = 8,
  parameter int unsigned DWB = 8,
  localparam int unsigned NPP = npp_of(DWB),
  localparam int unsigned PPW = DWA + 4
) (
  input  logic [DWA-1:0]           a,
  input  logic [DWB-1:0]           b,
  input  logic                     sgn,
  output logic [NPP-1:0][PPW-1:0]  pp,
  output logic [NPP-1:0]           neg
);

  logic [DWA:0]   a_ext;
  logic [DWB+2:0] b_x;     // {ext, ext, b, 0}: implicit b[-1] = 0 at bit 0
  logic [DWA+1:0] a1;
  logic [DWA+1:0] a2;
  logic [DWA+1:0] sel;
  logic [DWA+1:0] row;
  logic           s;
  booth_code_t    code;

  // Select +-a / +-2a per digit and attach the sign-extension prefix
  always_comb begin
    pp    = '0;
    neg   = '0;
    sel   = '0;
    row   = '0;
    s     = 1'b0;
    code  = '0;
    a_ext = {sgn & a[DWA-1], a};
    b_x   = {{2{sgn & b[DWB-1]}}, b, 1'b0};
    a1    = {a_ext[DWA], a_ext};
    a2    = {a_ext, 1'b0};
    for (int i = 0; i < NPP; i++) begin
      code   = booth_encode(b_x[2*i +: 3]);
      sel    = ({(DWA+2){code.one}} & a1) | ({(DWA+2){code.two}} & a2);
      row    = sel ^ {(DWA+2){code.neg}};
      s      = row[DWA+1];
      neg[i] = code.neg;
      // The prefix replaces the row MSB; row 0 is one bit wider than the rest
      if (i == 0) begin
        pp[i] = {Pfx0Base ^ {3{s}}, row[DWA:0]};
      end else begin
        pp[i] = {1'b0, PfxIBase ^ {1'b0, s}, row[DWA:0]};
      end
    end
  end

endmodule

// File: rtl/npu_booth_mac.sv
// Pipelined Booth multiply-accumulate lane: S1 registers partial products,
// S2 registers the summed product, then the accumulator and output register.
// The whole pipe stalls globally while a result waits for out_ready.
module npu_booth_mac
  import npu_mac_pkg::*;
#(
  parameter int unsigned DWA   = 8,
  parameter int unsigned DWB   = 8,
  parameter int unsigned DWACC = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DWA-1:0]   in_a,
  input  logic [DWB-1:0]   in_b,
  input  logic             in_signed,
  input  logic             in_clr,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DWACC-1:0] out_acc,
  output logic             out_ovf
);

  localparam int unsigned NPP = npp_of(DWB);
  localparam int unsigned PPW = DWA + 4;
  localparam int unsigned PW  = DWA + DWB;

  logic                    en;
  logic [NPP-1:0][PPW-1:0] pp_c;
  logic [NPP-1:0]          neg_c;

  logic                    s1_valid_q, s1_signed_q, s1_clr_q, s1_last_q;
  logic [NPP-1:0][PPW-1:0] s1_pp_q;
  logic [NPP-1:0]          s1_neg_q;

  logic [PW-1:0]           prod_c;
  logic                    s2_valid_q, s2_signed_q, s2_clr_q, s2_last_q;
  logic [PW-1:0]           s2_prod_q;

  logic [DWACC-1:0]        prod_ext;
  logic [DWACC:0]          sum_c;
  logic                    ovf_add;
  logic [DWACC-1:0]        acc_d, acc_q;
  logic                    ovf_d, ovf_q;
  logic                    grp_signed_d, grp_signed_q;

  assign in_ready = ~out_valid | out_ready;
  assign en       = in_ready;

  npu_booth_pp_gen #(
    .DWA (DWA),
    .DWB (DWB)
  ) u_pp_gen (
    .a   (in_a),
    .b   (in_b),
    .sgn (in_signed),
    .pp  (pp_c),
    .neg (neg_c)
  );

  // S1: capture partial products and beat control
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_signed_q <= 1'b0;
      s1_clr_q    <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_pp_q     <= '0;
      s1_neg_q    <= '0;
    end else if (en) begin
      s1_valid_q  <= in_valid;
      s1_signed_q <= in_signed;
      s1_clr_q    <= in_clr;
      s1_last_q   <= in_last;
      s1_pp_q     <= pp_c;
      s1_neg_q    <= neg_c;
    end
  end

  // Sum rows and completion bits modulo 2^(DWA+DWB)
  always_comb begin
    prod_c = '0;
    for (int i = 0; i < NPP; i++) begin
      prod_c = prod_c + (PW'(s1_pp_q[i]) << (2 * i)) + (PW'(s1_neg_q[i]) << (2 * i));
    end
  end

  // S2: capture the product
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q  <= 1'b0;
      s2_signed_q <= 1'b0;
      s2_clr_q    <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_prod_q   <= '0;
    end else if (en) begin
      s2_valid_q  <= s1_valid_q;
      s2_signed_q <= s1_signed_q;
      s2_clr_q    <= s1_clr_q;
      s2_last_q   <= s1_last_q;
      s2_prod_q   <= prod_c;
    end
  end

  // Accumulator next state; overflow follows the signedness of the clr beat
  always_comb begin
    prod_ext = DWACC'(s2_prod_q);
    for (int unsigned k = PW; k < DWACC; k++) begin
      prod_ext[k] = s2_signed_q & s2_prod_q[PW-1];
    end
    sum_c   = {1'b0, acc_q} + {1'b0, prod_ext};
    ovf_add = grp_signed_q ?
              ((acc_q[DWACC-1] == prod_ext[DWACC-1]) && (sum_c[DWACC-1] != acc_q[DWACC-1])) :
              sum_c[DWACC];
    acc_d        = acc_q;
    ovf_d        = ovf_q;
    grp_signed_d = grp_signed_q;
    if (s2_valid_q) begin
      if (s2_clr_q) begin
        acc_d        = prod_ext;
        ovf_d        = 1'b0;
        grp_signed_d = s2_signed_q;
      end else begin
        acc_d = sum_c[DWACC-1:0];
        ovf_d = ovf_q | ovf_add;
      end
    end
  end

  // Accumulator and output register; a stalled result holds its value
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q        <= '0;
      ovf_q        <= 1'b0;
      grp_signed_q <= 1'b0;
      out_valid    <= 1'b0;
      out_acc      <= '0;
      out_ovf      <= 1'b0;
    end else if (en) begin
      acc_q        <= acc_d;
      ovf_q        <= ovf_d;
      grp_signed_q <= grp_signed_d;
      out_valid    <= s2_valid_q & s2_last_q;
      if (s2_valid_q && s2_last_q) begin
        out_acc <= acc_d;
        out_ovf <= ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_npu_booth_mac.sv
// Directed bench for npu_booth_mac: a 24-bit lane and a 16-bit lane share inputs.
module tb_npu_booth_mac;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic        in_signed = 1'b0;
  logic        in_clr = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid, out_ovf;
  logic [23:0] out_acc;
  logic        in_ready16, out_valid16, out_ovf16;
  logic [15:0] out_acc16;

  int n_chk = 0;
  int n_err = 0;

  logic [23:0] q_acc[$];
  logic        q_ovf[$];
  logic [15:0] q16_acc[$];
  logic        q16_ovf[$];

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sg;
    logic        cl;
    logic        la;
    logic [23:0] acc;
    logic        ovf;
  } vec_t;

  vec_t tbl[11];

  always #5 clk = ~clk;

  npu_booth_mac dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_signed (in_signed),
    .in_clr    (in_clr),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_ovf   (out_ovf)
  );

  npu_booth_mac #(
    .DWACC (16)
  ) dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready16),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_signed (in_signed),
    .in_clr    (in_clr),
    .in_last   (in_last),
    .out_valid (out_valid16),
    .out_ready (out_ready),
    .out_acc   (out_acc16),
    .out_ovf   (out_ovf16)
  );

  // Record every output handshake, sampled with pre-edge values
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) begin
      q_acc.push_back(out_acc);
      q_ovf.push_back(out_ovf);
    end
    if (!rst && out_valid16 && out_ready) begin
      q16_acc.push_back(out_acc16);
      q16_ovf.push_back(out_ovf16);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b, input logic sg,
                              input logic cl, input logic la, input logic [23:0] acc);
    vec_t v;
    v.a = a; v.b = b; v.sg = sg; v.cl = cl; v.la = la; v.acc = acc; v.ovf = 1'b0;
    return v;
  endfunction

  // Drive one beat and return just after the edge that accepts it
  task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic sg,
                      input logic cl, input logic la, output int t_acc);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_signed = sg; in_clr = cl; in_last = la;
    while (!in_ready && n <= 50) begin
      @(negedge clk);
      n++;
    end
    if (n > 50) begin
      n_chk++; n_err++;
      $display("FAIL beat_accept: in_ready stuck low, got 0 expected 1");
    end
    @(posedge clk);
    t_acc = int'($time / 10);
    #1 in_valid = 1'b0;
  endtask

  task automatic pop(input bit w16, output logic [23:0] acc, output logic ovf);
    int n;
    n = 0;
    while (((w16 ? q16_acc.size() : q_acc.size()) == 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if ((w16 ? q16_acc.size() : q_acc.size()) == 0) begin
      n_chk++; n_err++;
      $display("FAIL pop_timeout: got no result expected one (w16=%0d)", w16);
      acc = '0; ovf = 1'b0;
    end else if (w16) begin
      acc = 24'(q16_acc.pop_front());
      ovf = q16_ovf.pop_front();
    end else begin
      acc = q_acc.pop_front();
      ovf = q_ovf.pop_front();
    end
  endtask

  task automatic flush();
    q_acc.delete(); q_ovf.delete(); q16_acc.delete(); q16_ovf.delete();
  endtask

  initial begin
    logic [23:0] acc;
    logic        ovf;
    int          t, t0, t1;

    tbl[0]  = mk(8'd255, 8'd255, 1'b0, 1'b1, 1'b1, 24'h00FE01);
    tbl[1]  = mk(8'h80,  8'h80,  1'b1, 1'b1, 1'b1, 24'h004000);
    tbl[2]  = mk(8'h80,  8'h7F,  1'b1, 1'b1, 1'b1, 24'hFFC080);
    tbl[3]  = mk(8'hFF,  8'hFF,  1'b1, 1'b1, 1'b1, 24'h000001);
    tbl[4]  = mk(8'h80,  8'h80,  1'b0, 1'b1, 1'b1, 24'h004000);
    tbl[5]  = mk(8'h07,  8'hFD,  1'b1, 1'b1, 1'b1, 24'hFFFFEB);
    tbl[6]  = mk(8'd200, 8'd3,   1'b0, 1'b1, 1'b1, 24'h000258);
    tbl[7]  = mk(8'd255, 8'd255, 1'b0, 1'b1, 1'b0, 24'h000000);
    tbl[8]  = mk(8'd255, 8'd255, 1'b0, 1'b0, 1'b1, 24'h01FC02);
    tbl[9]  = mk(8'h00,  8'h55,  1'b1, 1'b1, 1'b1, 24'h000000);
    tbl[10] = mk(8'h80,  8'hFF,  1'b1, 1'b1, 1'b1, 24'h000080);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_acc", 32'(out_acc), 32'd0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Latency: result visible after edge N+2, not N+1
    flush();
    beat(8'd255, 8'd255, 1'b0, 1'b1, 1'b1, t);
    @(negedge clk);
    chk("lat_after_n", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_after_n1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_after_n2", 32'(out_valid), 32'd1);
    pop(1'b0, acc, ovf);
    chk("uns_255x255_acc", 32'(acc), 32'h00FE01);
    chk("uns_255x255_ovf", 32'(ovf), 32'd0);

    // Back-to-back table at one beat per cycle
    flush();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      beat(tbl[i].a, tbl[i].b, tbl[i].sg, tbl[i].cl, tbl[i].la, t);
      if (i == 0) t0 = t;
      t1 = t;
    end
    chk("throughput_cycles", 32'(t1 - t0), 32'd10);
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].la) begin
        pop(1'b0, acc, ovf);
        chk($sformatf("tbl%0d_acc", i), 32'(acc), 32'(tbl[i].acc));
        chk($sformatf("tbl%0d_ovf", i), 32'(ovf), 32'(tbl[i].ovf));
      end
    end

    // Signed four-beat group
    flush();
    beat(8'd3,   8'd5,   1'b1, 1'b1, 1'b0, t);
    beat(8'hF9,  8'd2,   1'b1, 1'b0, 1'b0, t);
    beat(8'd100, 8'hFF,  1'b1, 1'b0, 1'b0, t);
    beat(8'd0,   8'd99,  1'b1, 1'b0, 1'b1, t);
    pop(1'b0, acc, ovf);
    chk("grp4_acc", 32'(acc), 32'hFFFF9D);
    chk("grp4_ovf", 32'(ovf), 32'd0);

    // 16-bit accumulator overflow, then a fresh group clears the flag
    repeat (3) @(negedge clk);
    flush();
    beat(8'h7F, 8'h7F, 1'b1, 1'b1, 1'b0, t);
    beat(8'h7F, 8'h7F, 1'b1, 1'b0, 1'b0, t);
    beat(8'h7F, 8'h7F, 1'b1, 1'b0, 1'b1, t);
    beat(8'h01, 8'h01, 1'b1, 1'b1, 1'b1, t);
    pop(1'b1, acc, ovf);
    chk("acc16_ovf_grp_acc", 32'(acc), 32'h00BD03);
    chk("acc16_ovf_grp_ovf", 32'(ovf), 32'd1);
    pop(1'b1, acc, ovf);
    chk("acc16_next_acc", 32'(acc), 32'd1);
    chk("acc16_next_ovf", 32'(ovf), 32'd0);
    pop(1'b0, acc, ovf);
    chk("acc24_same_grp_acc", 32'(acc), 32'h00BD03);
    chk("acc24_same_grp_ovf", 32'(ovf), 32'd0);
    pop(1'b0, acc, ovf);

    // Backpressure: held result, stalled input, nothing lost
    repeat (3) @(negedge clk);
    flush();
    out_ready = 1'b0;
    beat(8'd10, 8'd10, 1'b0, 1'b1, 1'b1, t);
    beat(8'd3,  8'd4,  1'b0, 1'b1, 1'b1, t);
    beat(8'd5,  8'd5,  1'b0, 1'b1, 1'b1, t);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("bp_in_ready_%0d", k), 32'(in_ready), 32'd0);
      chk($sformatf("bp_out_valid_%0d", k), 32'(out_valid), 32'd1);
      chk($sformatf("bp_out_acc_%0d", k), 32'(out_acc), 32'd100);
    end
    out_ready = 1'b1;
    beat(8'd7, 8'd7, 1'b0, 1'b1, 1'b1, t);
    pop(1'b0, acc, ovf);
    chk("bp_res0", 32'(acc), 32'd100);
    pop(1'b0, acc, ovf);
    chk("bp_res1", 32'(acc), 32'd12);
    pop(1'b0, acc, ovf);
    chk("bp_res2", 32'(acc), 32'd25);
    pop(1'b0, acc, ovf);
    chk("bp_res3", 32'(acc), 32'd49);

    // Reset with a pending output and an open group in flight
    repeat (3) @(negedge clk);
    flush();
    out_ready = 1'b0;
    beat(8'd9, 8'd9, 1'b0, 1'b1, 1'b1, t);
    beat(8'd5, 8'd5, 1'b0, 1'b1, 1'b0, t);
    beat(8'd6, 8'd6, 1'b0, 1'b0, 1'b0, t);
    @(negedge clk);
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    chk("post_rst_out_acc", 32'(out_acc), 32'd0);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_no_output", 32'(q_acc.size()), 32'd0);
    beat(8'd2, 8'd3, 1'b0, 1'b0, 1'b1, t);
    beat(8'd2, 8'd3, 1'b0, 1'b1, 1'b1, t);
    pop(1'b0, acc, ovf);
    chk("post_rst_accum_from_zero", 32'(acc), 32'd6);
    pop(1'b0, acc, ovf);
    chk("post_rst_clr_last", 32'(acc), 32'd6);
    chk("post_rst_clr_last_ovf", 32'(ovf), 32'd0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
